// File: rtl/regfile_2r1w_if.sv
// Register file access bus: two decode read ports, one writeback write port,
// a registered debug read port and the committed-write counter.
interface regfile_2r1w_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
);
  logic [AW-1:0] ra_addr;
  logic [DW-1:0] ra_data;
  logic [AW-1:0] rb_addr;
  logic [DW-1:0] rb_data;
  logic          we;
  logic [AW-1:0] wa_addr;
  logic [DW-1:0] wd;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic [15:0]   wr_count;

  // Pipeline side: issues addresses and writes, consumes read data
  modport master (
    output ra_addr, rb_addr, we, wa_addr, wd, dbg_addr,
    input  ra_data, rb_data, dbg_data, wr_count
  );

  // Register file side
  modport slave (
    input  ra_addr, rb_addr, we, wa_addr, wd, dbg_addr,
    output ra_data, rb_data, dbg_data, wr_count
  );
endinterface

// File: rtl/regfile_2r1w.sv
// 32 x 32 MIPS GPR file: two combinational read ports with optional same-cycle
// write forwarding, one synchronous write port, registered debug read port,
// and a wrapping count of committed writes. Register $0 reads as zero.
module regfile_2r1w #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 5,
  parameter bit          BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_2r1w_if.slave bus
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = 16;

  // Entry 0 has no storage; it is decoded to zero on every read path
  logic [DW-1:0] r_mem [1:DEPTH-1];
  logic [DW-1:0] r_dbg_data;
  logic [CW-1:0] r_wr_count;

  logic          w_wr_en;
  logic          w_fwd_en;
  logic [DW-1:0] w_ra_data;
  logic [DW-1:0] w_rb_data;

  // A write commits only to a non-zero destination
  assign w_wr_en  = bus.we && (bus.wa_addr != '0);
  // Forwarding is suppressed during reset so reads agree with the cleared array
  assign w_fwd_en = BYPASS && w_wr_en && !rst;

  // Read mux shared by ports A and B
  function automatic logic [DW-1:0] read_port(input logic [AW-1:0] addr);
    logic [DW-1:0] val;
    val = '0;
    if (addr != '0) begin
      if (w_fwd_en && (addr == bus.wa_addr)) begin
        val = bus.wd;
      end else begin
        val = r_mem[addr];
      end
    end
    return val;
  endfunction

  // Storage array: cleared on reset, written at the clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[bus.wa_addr] <= bus.wd;
    end
  end

  // Committed-write counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_count <= '0;
    end else if (w_wr_en) begin
      r_wr_count <= r_wr_count + CW'(1);
    end
  end

  // Debug port samples the pre-write stored value, no forwarding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dbg_data <= '0;
    end else if (bus.dbg_addr == '0) begin
      r_dbg_data <= '0;
    end else begin
      r_dbg_data <= r_mem[bus.dbg_addr];
    end
  end

  // Combinational decode read ports
  always_comb begin
    w_ra_data = '0;
    w_rb_data = '0;
    w_ra_data = read_port(bus.ra_addr);
    w_rb_data = read_port(bus.rb_addr);
  end

  assign bus.ra_data  = w_ra_data;
  assign bus.rb_data  = w_rb_data;
  assign bus.dbg_data = r_dbg_data;
  assign bus.wr_count = r_wr_count;

endmodule
